cs_frame_packer: RTL
====================

# cs_frame_packer

Downstream stage of the computational system (CS) core. It consumes the 10-bit Y result stream, one sample per qualified cycle, and buffers samples in a first-word-fall-through FIFO. Samples leave through a valid/ready handshake. Per-frame statistics (max, min, sum over FRAME_LEN samples) are produced with a one-cycle done pulse, so the result sink never stalls the CS core.

## Interface
- DATA_W, 10, sample width (matches CS Y output)
- DEPTH, 16, FIFO entries; power of two, ≥2
- FRAME_LEN, 8, samples per statistics frame; 1..256
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- y_in  input  DATA_W  result sample from CS
- y_valid  input  1  y_in carries a valid sample this cycle
- out_data  output  DATA_W  FIFO head; meaningful only while out_valid=1
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  sink accepts out_data this cycle
- level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky; a sample was dropped because the FIFO was full
- frame_done  output  1  one-cycle pulse; frame_* registers just updated
- frame_max  output  DATA_W  largest sample of the last completed frame
- frame_min  output  DATA_W  smallest sample of the last completed frame
- frame_sum  output  DATA_W+8  sum of the last completed frame (no overflow possible at FRAME_LEN≤256)

## Operation
- Pop: out_valid && out_ready. Head advances; out_data shows the next entry in the same cycle the pointer update lands.
- Push: y_valid && (level<DEPTH || pop). Full with a simultaneous pop accepts the push; level stays DEPTH.
- Drop: y_valid && level==DEPTH && !pop. Sample is discarded and overflow is set. overflow clears only on reset.
- Empty with y_valid: push only. No pop is possible since out_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is tracked explicitly (+1 push, -1 pop, unchanged on both or neither).
- Statistics run on every y_valid sample, including dropped ones, so they reflect the input stream and not the FIFO contents.
- Accumulators: run_max, run_min, run_sum, and sample counter cnt (0..FRAME_LEN-1).
- Sample with cnt==0: accumulators load the sample directly (max=min=sum=y_in) and cnt becomes 1.
- Other samples: max/min compare is unsigned. sum adds zero-extended y_in.
- Sample with cnt==FRAME_LEN-1: frame_max/min/sum are written with the accumulated value including this sample. frame_done is asserted for the next cycle only, and cnt returns to 0.
- FRAME_LEN==1: every valid sample completes a frame.
- frame_* outputs hold until the next frame completion.
- Cycles with y_valid=0 leave all statistics state unchanged. Partial frames persist indefinitely.

## Timing
- Reset (synchronous, checked at rising edge) applies to all state, taking priority over push/pop in the same cycle:
  - pointers, level=0, out_valid=0, out_data=0
  - overflow=0, frame_done=0, frame_max=0, frame_min=0, frame_sum=0, cnt=0
- Reset mid-frame discards the partial frame. Reset with FIFO content discards all entries.
- Push→out latency: a sample pushed at edge k into an empty FIFO gives out_valid=1 and out_data=sample after edge k. The earliest pop is at edge k+1.
- level and out_valid update at the same edge as the push/pop causing them.
- frame_done is high for exactly the cycle following the edge that captured the last sample of a frame. It is never high for two consecutive cycles unless two consecutive frames complete (FRAME_LEN==1 with back-to-back y_valid).
- Throughput: one push and one pop per cycle sustained. No bubbles at full.

## Test plan
- Reset then stream y_in=1..8 with y_valid=1 and out_ready=1 (DEPTH=16, FRAME_LEN=8) → out_data 1..8 each one cycle after push, level ≤1. frame_done pulses once, with frame_max=8, frame_min=1, frame_sum=36.
- out_ready=0, push 17 samples 100..116 → level=16 after the 16th, sample 116 dropped, overflow=1. Then out_ready=1 drains 100..115 in order, level returns to 0, and overflow stays 1.
- Full FIFO, y_valid=1 and out_ready=1 in the same cycle → push accepted, head popped, level stays 16, overflow unchanged.
- Gapped input 1023, idle 3 cycles, then 0, 5, 5, 5, 5, 5, 5 → one frame_done with frame_max=1023, frame_min=0, frame_sum=1053.
- Assert reset after 3 samples of a frame with 3 entries in the FIFO → next cycle: out_valid=0, level=0, frame_*=0, overflow=0. The next 8 samples form a fresh frame.
- FRAME_LEN=1, y_in=7 then 9 back-to-back → frame_done high 2 consecutive cycles, with frame_max=frame_min=frame_sum=7 then 9.

Source files
------------

// File: rtl/cs_frame_packer.sv
// cs_frame_packer: FWFT sample FIFO with per-frame max/min/sum statistics.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   y_in, y_valid         sample stream from the CS core
//   out_data, out_valid   FIFO head (FWFT), valid while non-empty
//   out_ready             sink accepts the head this cycle
//   level                 FIFO occupancy 0..DEPTH
//   overflow              sticky: a sample was dropped on a full FIFO
//   frame_done            one-cycle pulse after a frame completes
//   frame_max/min/sum     statistics of the last completed frame
module cs_frame_packer #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         y_in,
    input  logic                      y_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      frame_done,
    output logic [DATA_W-1:0]         frame_max,
    output logic [DATA_W-1:0]         frame_min,
    output logic [DATA_W+7:0]         frame_sum
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam int SW = DATA_W + 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [AW:0]       r_level;
    logic              r_ovf;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_max, r_min;
    logic [SW-1:0]     r_sum;
    logic              r_done;
    logic [DATA_W-1:0] r_fmax, r_fmin;
    logic [SW-1:0]     r_fsum;

    logic              w_pop, w_push, w_full, w_first, w_last;
    logic [DATA_W-1:0] w_max, w_min;
    logic [SW-1:0]     w_sum;

    assign w_full  = r_level == (AW+1)'(DEPTH);
    assign w_pop   = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = y_valid && (!w_full || w_pop);
    assign w_first = r_cnt == '0;
    assign w_last  = r_cnt == CW'(FRAME_LEN - 1);

    // Next accumulator values including the current sample; a frame's first
    // sample loads directly so no separate clear cycle is needed.
    always_comb begin
        w_max = w_first ? y_in : (y_in > r_max ? y_in : r_max);
        w_min = w_first ? y_in : (y_in < r_min ? y_in : r_min);
        w_sum = w_first ? SW'(y_in) : r_sum + SW'(y_in);
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= y_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (!w_push && w_pop)
                r_level <= r_level - 1'b1;
            if (y_valid && !w_push)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_max  <= '0;
            r_min  <= '0;
            r_sum  <= '0;
            r_done <= 1'b0;
            r_fmax <= '0;
            r_fmin <= '0;
            r_fsum <= '0;
        end else begin
            r_done <= y_valid && w_last;
            if (y_valid) begin
                r_max <= w_max;
                r_min <= w_min;
                r_sum <= w_sum;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_fmax <= w_max;
                    r_fmin <= w_min;
                    r_fsum <= w_sum;
                end
            end
        end
    end

    assign out_valid  = r_level != '0;
    assign out_data   = out_valid ? r_mem[r_rd] : '0;
    assign level      = r_level;
    assign overflow   = r_ovf;
    assign frame_done = r_done;
    assign frame_max  = r_fmax;
    assign frame_min  = r_fmin;
    assign frame_sum  = r_fsum;
endmodule
